aes_spi_frontend: RTL and testbench

Parametrised SPI slave frame engine that sits between the external SPI master and the AES round core. It shifts in a header, a 128-bit block and an optional K-bit key, and launches the core through a start/done handshake. It then shifts the 128-bit result back out. It generalises the single-shot load/done SPI interface with K ∈ {128, 192, 256}, a direction mode, key reuse across frames and framing-error detection.

---
 rtl/aes_spi_frontend.sv | 220 ++++++++++++++++++++++
 tb/tb_aes_spi_frontend.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_frontend.sv
// SPI slave frame engine in front of the AES round core: shifts in header, block
// and optional key, runs the core start/done handshake, then shifts the result out.
module aes_spi_frontend #(
    parameter int unsigned K   = 128,
    parameter int unsigned INV = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sck,
    input  logic           sdi,
    input  logic           load,
    output logic           sdo,
    output logic           done,
    output logic           err,
    output logic           core_start,
    output logic           core_dir,
    output logic [127:0]   core_block,
    output logic [K-1:0]   core_key,
    input  logic           core_done,
    input  logic [127:0]   core_result
);
    localparam int unsigned HW    = 8;
    localparam int unsigned BW    = 128;
    localparam int unsigned DW    = BW + K;
    localparam int unsigned LKEEP = HW + BW;
    localparam int unsigned LFULL = HW + BW + K;
    localparam int unsigned CW    = $clog2(LFULL + 1);

    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic          DIR_FIXED   = (INV == 1);
    localparam logic          DIR_RUNTIME = (INV == 2);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        START,
        BUSY,
        OUT
    } state_t;

    // [0] metastability flop, [1] synchronised level, [2] previous level for edge detect
    logic [2:0] sck_q;
    logic [2:0] load_q;
    logic [1:0] sdi_q;

    logic sck_rise;
    logic sck_fall;
    logic load_rise;
    logic load_fall;
    logic load_lvl;
    logic sdi_s;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hdr_q, hdr_d;
    logic [DW-1:0] din_q, din_d;
    logic [BW-1:0] res_q, res_d;
    logic          key_valid_q, key_valid_d;

    logic          done_d;
    logic          err_d;
    logic          core_start_d;
    logic          core_dir_d;
    logic [BW-1:0] core_block_d;
    logic [K-1:0]  core_key_d;

    logic [CW-1:0] len;
    logic          keep;
    logic          hdr_bad;
    logic [CW-1:0] cnt_inc;
    logic          sck_any;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_q  <= '0;
            load_q <= '0;
            sdi_q  <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            load_q <= {load_q[1:0], load};
            sdi_q  <= {sdi_q[0], sdi};
        end
    end

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign sck_any   = sck_rise | sck_fall;
    assign load_rise = load_q[1] & ~load_q[2];
    assign load_fall = ~load_q[1] & load_q[2];
    assign load_lvl  = load_q[1];
    assign sdi_s     = sdi_q[1];

    // Expected frame length is only meaningful once the 8 header bits are in
    assign keep    = hdr_q[0] & key_valid_q;
    assign hdr_bad = hdr_q[0] & ~key_valid_q;
    assign len     = keep ? CW'(LKEEP) : CW'(LFULL);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    assign sdo = res_q[BW-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hdr_q       <= '0;
            din_q       <= '0;
            res_q       <= '0;
            key_valid_q <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            core_start  <= 1'b0;
            core_dir    <= 1'b0;
            core_block  <= '0;
            core_key    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            din_q       <= din_d;
            res_q       <= res_d;
            key_valid_q <= key_valid_d;
            done        <= done_d;
            err         <= err_d;
            core_start  <= core_start_d;
            core_dir    <= core_dir_d;
            core_block  <= core_block_d;
            core_key    <= core_key_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hdr_d        = hdr_q;
        din_d        = din_q;
        res_d        = res_q;
        key_valid_d  = key_valid_q;
        done_d       = done;
        err_d        = err;
        core_start_d = 1'b0;
        core_dir_d   = core_dir;
        core_block_d = core_block;
        core_key_d   = core_key;

        unique case (state_q)
            IDLE: begin
                if (load_rise) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    hdr_d   = '0;
                    state_d = SHIFT_IN;
                end
            end

            SHIFT_IN: begin
                // An sck rise landing with the load fall is taken first
                if (sck_rise) begin
                    if (cnt_q < CW'(HW)) begin
                        hdr_d = {hdr_q[HW-2:0], sdi_s};
                    end else if (cnt_q < len) begin
                        din_d = {din_q[DW-2:0], sdi_s};
                    end
                    cnt_d = cnt_inc;
                end
                if (load_fall) begin
                    if ((cnt_d == len) && !hdr_bad) begin
                        if (keep) begin
                            core_block_d = din_d[BW-1:0];
                        end else begin
                            core_block_d = din_d[DW-1:K];
                            core_key_d   = din_d[K-1:0];
                            key_valid_d  = 1'b1;
                        end
                        core_dir_d   = DIR_RUNTIME ? hdr_q[HW-1] : DIR_FIXED;
                        core_start_d = 1'b1;
                        state_d      = START;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            START: begin
                if (load_rise || sck_any) begin
                    err_d = 1'b1;
                end
                state_d = BUSY;
            end

            BUSY: begin
                if (load_rise || sck_any) begin
                    err_d = 1'b1;
                end
                if (core_done) begin
                    res_d   = core_result;
                    done_d  = 1'b1;
                    state_d = OUT;
                end
            end

            OUT: begin
                // Shift on sck fall so the master samples a stable bit on sck rise
                if (load_lvl && sck_fall) begin
                    res_d = {res_q[BW-2:0], 1'b0};
                end
                if (load_fall) begin
                    res_d   = '0;
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_spi_frontend.sv
// Bench for aes_spi_frontend: three instances (K=192/INV=2, K=256/INV=2, K=128/INV=0)
// driven by directed SPI frames, checked against a frame-level model and literals.
module tb_aes_spi_frontend;
    localparam int ND = 3;

    localparam logic [127:0] B1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    localparam logic [127:0] B3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KALT = 256'h0f0e0d0c0b0a09080706050403020100f1f2f3f4f5f6f7f8;
    localparam logic [127:0] R_ENC192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    logic         clk;
    logic         sck [ND];
    logic         sdi [ND];
    logic         load [ND];
    logic         rst [ND];
    logic         core_done [ND];
    logic [127:0] core_result [ND];
    logic         sdo [ND];
    logic         done [ND];
    logic         err [ND];
    logic         core_start [ND];
    logic         core_dir [ND];
    logic [127:0] core_block [ND];
    logic [191:0] key0;
    logic [255:0] key1;
    logic [127:0] key2;
    logic [255:0] ckey [ND];

    assign ckey[0] = 256'(key0);
    assign ckey[1] = key1;
    assign ckey[2] = 256'(key2);

    // Frame-level model state and core model
    logic [255:0] m_key [ND];
    logic [127:0] m_block [ND];
    logic         m_kv [ND];
    logic         m_dir [ND];
    logic         m_err [ND];
    int           m_nstart [ND];
    int           n_start [ND];
    logic [127:0] resp [ND];
    int           lat [ND];
    int           timer [ND];

    int checks;
    int errors;

    aes_spi_frontend #(.K(192), .INV(2)) u_dut0 (
        .clk(clk), .reset(rst[0]), .sck(sck[0]), .sdi(sdi[0]), .load(load[0]),
        .sdo(sdo[0]), .done(done[0]), .err(err[0]), .core_start(core_start[0]),
        .core_dir(core_dir[0]), .core_block(core_block[0]), .core_key(key0),
        .core_done(core_done[0]), .core_result(core_result[0])
    );

    aes_spi_frontend #(.K(256), .INV(2)) u_dut1 (
        .clk(clk), .reset(rst[1]), .sck(sck[1]), .sdi(sdi[1]), .load(load[1]),
        .sdo(sdo[1]), .done(done[1]), .err(err[1]), .core_start(core_start[1]),
        .core_dir(core_dir[1]), .core_block(core_block[1]), .core_key(key1),
        .core_done(core_done[1]), .core_result(core_result[1])
    );

    aes_spi_frontend #(.K(128), .INV(0)) u_dut2 (
        .clk(clk), .reset(rst[2]), .sck(sck[2]), .sdi(sdi[2]), .load(load[2]),
        .sdo(sdo[2]), .done(done[2]), .err(err[2]), .core_start(core_start[2]),
        .core_dir(core_dir[2]), .core_block(core_block[2]), .core_key(key2),
        .core_done(core_done[2]), .core_result(core_result[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int k_of(input int d);
        case (d)
            0:       return 192;
            1:       return 256;
            default: return 128;
        endcase
    endfunction

    function automatic int inv_of(input int d);
        return (d == 2) ? 0 : 2;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset(input int d);
        m_key[d]   = '0;
        m_block[d] = '0;
        m_kv[d]    = 1'b0;
        m_dir[d]   = 1'b0;
        m_err[d]   = 1'b0;
    endtask

    // What a frame of nbits must do, straight from the framing rules
    task automatic model_frame(input int d, input logic [7:0] hdr, input logic [127:0] blk,
                               input logic [255:0] key, input int nbits);
        int   len;
        logic ok;
        len = (hdr[0] && m_kv[d]) ? 136 : 136 + k_of(d);
        ok  = !(hdr[0] && !m_kv[d]) && (nbits == len);
        m_err[d] = !ok;
        if (ok) begin
            m_nstart[d]++;
            m_block[d] = blk;
            if (!hdr[0]) begin
                m_key[d] = key & ((256'(1) << k_of(d)) - 256'(1));
                m_kv[d]  = 1'b1;
            end
            m_dir[d] = (inv_of(d) == 2) ? hdr[7] : 1'(inv_of(d) == 1);
        end
    endtask

    // Compare process plus core model, sampled on the falling clk edge
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                core_done[d] = 1'b0;
                if (timer[d] > 0) begin
                    timer[d]--;
                    if (timer[d] == 0) begin
                        core_done[d]   = 1'b1;
                        core_result[d] = resp[d];
                    end
                end
                if (core_start[d]) begin
                    chk("start_count", 256'(n_start[d] + 1), 256'(m_nstart[d]));
                    chk("start_block", 256'(core_block[d]), 256'(m_block[d]));
                    chk("start_key", ckey[d], m_key[d]);
                    chk("start_dir", 256'(core_dir[d]), 256'(m_dir[d]));
                    n_start[d]++;
                    timer[d] = lat[d];
                end
                if (done[d]) begin
                    chk("done_key", ckey[d], m_key[d]);
                    chk("done_block", 256'(core_block[d]), 256'(m_block[d]));
                end
            end
        end
    endtask

    task automatic send_frame(input int d, input logic [7:0] hdr, input logic [127:0] blk,
                              input logic [255:0] key, input int nbits);
        logic [391:0] f;
        f = {hdr, blk, key << (256 - k_of(d))};
        load[d] = 1'b1;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            sdi[d] = f[391];
            f = f << 1;
            wait_clk(2);
            sck[d] = 1'b1;
            wait_clk(4);
            sck[d] = 1'b0;
            wait_clk(2);
        end
        wait_clk(4);
        model_frame(d, hdr, blk, key, nbits);
        load[d] = 1'b0;
        wait_clk(8);
        chk("err_after_frame", 256'(err[d]), 256'(m_err[d]));
    endtask

    task automatic read_result(input int d, input logic [127:0] expv, input string name);
        logic [127:0] r;
        int t;
        r = '0;
        t = 0;
        while (!done[d] && t < 400) begin
            wait_clk(1);
            t++;
        end
        chk({name, "_done"}, 256'(done[d]), 256'(1));
        load[d] = 1'b1;
        wait_clk(5);
        for (int i = 0; i < 128; i++) begin
            r = {r[126:0], sdo[d]};
            sck[d] = 1'b1;
            wait_clk(4);
            sck[d] = 1'b0;
            wait_clk(5);
        end
        chk({name, "_data"}, 256'(r), 256'(expv));
        load[d] = 1'b0;
        wait_clk(6);
        chk({name, "_done_clr"}, 256'(done[d]), 256'(0));
        chk({name, "_sdo_clr"}, 256'(sdo[d]), 256'(0));
    endtask

    task automatic check_zero(input int d, input string name);
        chk({name, "_sdo"}, 256'(sdo[d]), 256'(0));
        chk({name, "_done"}, 256'(done[d]), 256'(0));
        chk({name, "_err"}, 256'(err[d]), 256'(0));
        chk({name, "_start"}, 256'(core_start[d]), 256'(0));
        chk({name, "_dir"}, 256'(core_dir[d]), 256'(0));
        chk({name, "_block"}, 256'(core_block[d]), 256'(0));
        chk({name, "_key"}, ckey[d], 256'(0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int d = 0; d < ND; d++) begin
            sck[d] = 1'b0;
            sdi[d] = 1'b0;
            load[d] = 1'b0;
            rst[d] = 1'b1;
            core_done[d] = 1'b0;
            core_result[d] = '0;
            resp[d] = '0;
            timer[d] = 0;
            m_nstart[d] = 0;
            n_start[d] = 0;
            model_reset(d);
        end
        lat[0] = 12;
        lat[1] = 12;
        lat[2] = 40;
        fork
            monitor();
        join_none

        wait_clk(3);
        for (int d = 0; d < ND; d++) check_zero(d, "reset");
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;
        wait_clk(4);

        // Key reuse requested with no stored key
        send_frame(0, 8'h01, B1, '0, 136);
        chk("nokey_err", 256'(err[0]), 256'(1));
        chk("nokey_nostart", 256'(n_start[0]), 256'(0));

        // K=192 encrypt
        resp[0] = R_ENC192;
        send_frame(0, 8'h00, B1, K192, 328);
        chk("enc192_dir", 256'(core_dir[0]), 256'(0));
        chk("enc192_key", ckey[0], K192);
        chk("enc192_block", 256'(core_block[0]), 256'(B1));
        read_result(0, R_ENC192, "enc192");
        chk("enc192_starts", 256'(n_start[0]), 256'(1));

        // Short frame leaves key, block and key_valid alone
        send_frame(0, 8'h00, B2, KALT, 108);
        chk("short_err", 256'(err[0]), 256'(1));
        chk("short_nostart", 256'(n_start[0]), 256'(1));
        chk("short_block", 256'(core_block[0]), 256'(B1));
        resp[0] = 128'hcafef00d_0badbeef_12345678_9abcdef0;
        send_frame(0, 8'h01, B2, '0, 136);
        chk("short_keep_key", ckey[0], K192);
        chk("short_keep_block", 256'(core_block[0]), 256'(B2));
        read_result(0, 128'hcafef00d_0badbeef_12345678_9abcdef0, "keep192");

        // Reset while BUSY, then a late core_done must be ignored
        resp[0] = 128'h55555555_aaaaaaaa_33333333_cccccccc;
        send_frame(0, 8'h00, B1, K192, 328);
        chk("rb_starts", 256'(n_start[0]), 256'(3));
        rst[0] = 1'b1;
        model_reset(0);
        wait_clk(1);
        check_zero(0, "rb_reset");
        wait_clk(1);
        rst[0] = 1'b0;
        wait_clk(20);
        chk("rb_late_done", 256'(done[0]), 256'(0));
        chk("rb_late_sdo", 256'(sdo[0]), 256'(0));
        resp[0] = 128'h0123456789abcdeffedcba9876543210;
        send_frame(0, 8'h00, B2, KALT, 328);
        chk("rb_new_key", ckey[0], KALT & ((256'(1) << 192) - 256'(1)));
        read_result(0, 128'h0123456789abcdeffedcba9876543210, "rb_after");
        chk("rb_total_starts", 256'(n_start[0]), 256'(4));

        // K=256 decrypt, then reuse the stored key
        resp[1] = B1;
        send_frame(1, 8'h80, B3, K256, 392);
        chk("dec256_dir", 256'(core_dir[1]), 256'(1));
        chk("dec256_key", ckey[1], K256);
        read_result(1, B1, "dec256");
        resp[1] = 128'hdeadbeef_00000000_ffffffff_13572468;
        send_frame(1, 8'h81, B3, '0, 136);
        chk("reuse256_dir", 256'(core_dir[1]), 256'(1));
        chk("reuse256_key", ckey[1], K256);
        chk("reuse256_block", 256'(core_block[1]), 256'(B3));
        read_result(1, 128'hdeadbeef_00000000_ffffffff_13572468, "reuse256");
        chk("reuse256_starts", 256'(n_start[1]), 256'(2));

        // INV=0 ignores hdr[7]; sck activity while BUSY flags err
        resp[2] = B3;
        send_frame(2, 8'h80, B1, K128, 264);
        sck[2] = 1'b1;
        wait_clk(4);
        sck[2] = 1'b0;
        wait_clk(4);
        chk("inv0_busy_err", 256'(err[2]), 256'(1));
        chk("inv0_dir", 256'(core_dir[2]), 256'(0));
        chk("inv0_key", ckey[2], K128);
        read_result(2, B3, "inv0");
        chk("inv0_starts", 256'(n_start[2]), 256'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
